// File: rtl/w1_detrans.sv
// w1_detrans: converts a (p+1)-digit W1-coded radix-4 signed-digit vector into a plain
// radix-4 (binary) vector plus a final borrow flag. Conversion runs serially, CHUNK digits
// per cycle, LSB chunk first. The borrow ripples combinationally within a chunk and is
// registered between chunks.
//
// Digit coding: 00 = 0, 01 = +1, 10 = +2, 11 = -1.
//
// Parameters:
//   p      number of operand digits; vectors carry p+1 digits (2p+2 bits)
//   CHUNK  digits converted per cycle, 1..p+1
//
// Ports:
//   clk        system clock, rising edge
//   rst_n      asynchronous active-low reset
//   in_valid   input vector valid
//   in_ready   block can accept a vector (decoded from state)
//   w1         W1-coded input vector, digit i at w1[2i+1:2i]
//   out_valid  result valid
//   out_ready  consumer accepts result
//   q          converted value mod 4^(p+1), digit i at q[2i+1:2i]
//   neg        final borrow; 1 means the value is negative and q is its 4^(p+1) complement
//   err        top-digit marker error (only with W1_DETRANS_TOPCHK_EN defined)
//
// Optional feature macro: W1_DETRANS_TOPCHK_EN. When defined, err is registered on accept as
// (top digit != 01) and held until the next accept or reset.

module w1_detrans #(
   parameter int unsigned p     = 33,
   parameter int unsigned CHUNK = 4
) (
   input  logic           clk,
   input  logic           rst_n,
   input  logic           in_valid,
   output logic           in_ready,
   input  logic [2*p+1:0] w1,
   output logic           out_valid,
   input  logic           out_ready,
   output logic [2*p+1:0] q,
   output logic           neg
`ifdef W1_DETRANS_TOPCHK_EN
   ,
   output logic           err
`endif
);

   localparam int unsigned W     = 2 * p + 2;
   localparam int unsigned ND    = p + 1;
   localparam int unsigned NBEAT = (ND + CHUNK - 1) / CHUNK;
   localparam int unsigned BEATW = (NBEAT > 1) ? $clog2(NBEAT) : 1;
   localparam logic [BEATW-1:0] LastBeat = BEATW'(NBEAT - 1);

   typedef enum logic [1:0] {StIdle, StConv, StDone} state_e;

   state_e           state_q;
   logic [W-1:0]     sr_q;
   logic [W-1:0]     q_q, q_d;
   logic             borrow_q, borrow_d;
   logic [BEATW-1:0] beat_q;
   logic             neg_q;
   logic             out_valid_q;

   logic             b;
   logic [1:0]       dig;
   int unsigned      idx;

   // Convert the current chunk. The shift register always presents the current chunk at its
   // bottom, so chunk digit j sits at sr_q[2j+1:2j] and lands at absolute position
   // beat*CHUNK + j. Positions above p in the last chunk must not touch the borrow.
   always_comb begin
      q_d = q_q;
      b   = borrow_q;
      dig = 2'b00;
      idx = 0;
      for (int unsigned j = 0; j < CHUNK; j++) begin
         idx = 32'(beat_q) * CHUNK + j;
         dig = sr_q[2*j +: 2];
         if (idx < ND) begin
            // s = d + b with b in {0,-1}: the output digit is (code - b) mod 4, and a borrow
            // leaves for d = -1, or for d = 0 with an incoming borrow.
            q_d[2*idx +: 2] = dig - {1'b0, b};
            b = (dig == 2'b11) | (b & (dig == 2'b00));
         end
      end
      borrow_d = b;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= StIdle;
         sr_q        <= '0;
         q_q         <= '0;
         borrow_q    <= 1'b0;
         beat_q      <= '0;
         neg_q       <= 1'b0;
         out_valid_q <= 1'b0;
      end else begin
         unique case (state_q)
            StIdle: begin
               if (in_valid) begin
                  sr_q     <= w1;
                  borrow_q <= 1'b0;
                  beat_q   <= '0;
                  state_q  <= StConv;
               end
            end
            StConv: begin
               q_q      <= q_d;
               borrow_q <= borrow_d;
               sr_q     <= sr_q >> (2 * CHUNK);
               if (beat_q == LastBeat) begin
                  neg_q       <= borrow_d;
                  out_valid_q <= 1'b1;
                  beat_q      <= '0;
                  state_q     <= StDone;
               end else begin
                  beat_q <= beat_q + 1'b1;
               end
            end
            StDone: begin
               if (out_ready) begin
                  out_valid_q <= 1'b0;
                  state_q     <= StIdle;
               end
            end
            default: state_q <= StIdle;
         endcase
      end
   end

`ifdef W1_DETRANS_TOPCHK_EN
   logic err_q;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         err_q <= 1'b0;
      end else if (state_q == StIdle && in_valid) begin
         err_q <= (w1[W-1 -: 2] != 2'b01);
      end
   end

   assign err = err_q;
`endif

   assign in_ready  = (state_q == StIdle);
   assign out_valid = out_valid_q;
   assign q         = q_q;
   assign neg       = neg_q;

endmodule

// File: tb/tb_w1_detrans.sv
// Bench for w1_detrans: a small p=3/CHUNK=2 instance for directed cases (ripple, negative,
// backpressure, reset mid-conversion) and a default p=33/CHUNK=4 instance for random vectors
// checked against an arithmetic value model.

module tb_w1_detrans;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   // Small instance
   logic       s_in_valid = 1'b0;
   logic       s_in_ready;
   logic [7:0] s_w1 = '0;
   logic       s_out_valid;
   logic       s_out_ready = 1'b1;
   logic [7:0] s_q;
   logic       s_neg;

   // Default-size instance
   logic        b_in_valid = 1'b0;
   logic        b_in_ready;
   logic [67:0] b_w1 = '0;
   logic        b_out_valid;
   logic        b_out_ready = 1'b1;
   logic [67:0] b_q;
   logic        b_neg;

`ifdef W1_DETRANS_TOPCHK_EN
   logic s_err;
   logic b_err;
`endif

   w1_detrans #(.p(3), .CHUNK(2)) u_small (
      .clk       (clk),
      .rst_n     (rst_n),
      .in_valid  (s_in_valid),
      .in_ready  (s_in_ready),
      .w1        (s_w1),
      .out_valid (s_out_valid),
      .out_ready (s_out_ready),
      .q         (s_q),
      .neg       (s_neg)
`ifdef W1_DETRANS_TOPCHK_EN
      ,
      .err       (s_err)
`endif
   );

   w1_detrans #(.p(33), .CHUNK(4)) u_big (
      .clk       (clk),
      .rst_n     (rst_n),
      .in_valid  (b_in_valid),
      .in_ready  (b_in_ready),
      .w1        (b_w1),
      .out_valid (b_out_valid),
      .out_ready (b_out_ready),
      .q         (b_q),
      .neg       (b_neg)
`ifdef W1_DETRANS_TOPCHK_EN
      ,
      .err       (b_err)
`endif
   );

   int n_pass  = 0;
   int n_total = 0;
   int cyc     = 0;

   always @(posedge clk) cyc <= cyc + 1;

   task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
      n_total++;
      if (got === exp) n_pass++;
      else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
   endtask

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   // Signed value of a W1 vector: sum(d_i * 4^i).
   function automatic logic signed [71:0] w1_value(input logic [71:0] v, input int nd);
      logic signed [71:0] acc;
      logic signed [71:0] dd;
      int                 dv;
      acc = '0;
      for (int i = nd - 1; i >= 0; i--) begin
         case (v[2*i +: 2])
            2'b00:   dv = 0;
            2'b01:   dv = 1;
            2'b10:   dv = 2;
            default: dv = -1;
         endcase
         dd  = dv;
         acc = (acc <<< 2) + dd;
      end
      return acc;
   endfunction

   // One transaction on the small instance; hold > 0 applies backpressure for that many
   // cycles while offering a second vector that must be ignored.
   task automatic small_run(input logic [7:0] v, input logic [7:0] eq, input logic en,
                            input logic ee, input int hold);
      int lat;
      check("s_ready_before", s_in_ready, 1);
      s_w1        = v;
      s_in_valid  = 1'b1;
      s_out_ready = (hold == 0);
      tick;
      s_in_valid = 1'b0;
      lat = 1;
      while (!s_out_valid && lat < 20) begin
         tick;
         lat++;
      end
      check("s_latency", lat, 3);
      check("s_q", s_q, eq);
      check("s_neg", s_neg, en);
`ifdef W1_DETRANS_TOPCHK_EN
      check("s_err", s_err, ee);
`else
      if (ee === 1'bx) $display("unexpected x in err expectation");
`endif
      if (hold > 0) begin
         s_in_valid = 1'b1;
         s_w1       = 8'h55;
         for (int i = 0; i < hold; i++) begin
            tick;
            check("s_hold_valid", s_out_valid, 1);
            check("s_hold_q", s_q, eq);
            check("s_hold_neg", s_neg, en);
            check("s_hold_ready", s_in_ready, 0);
         end
         s_in_valid  = 1'b0;
         s_out_ready = 1'b1;
      end
      tick;
      check("s_idle_valid", s_out_valid, 0);
      check("s_idle_ready", s_in_ready, 1);
   endtask

   initial begin
      logic [95:0]        r;
      logic [67:0]        v;
      logic signed [71:0] val;
      int                 lat;
      int                 k;
      int                 acc_cyc;
      int                 prev_cyc;

      // Reset state
      #12;
      check("rst_s_valid", s_out_valid, 0);
      check("rst_s_q", s_q, 0);
      check("rst_s_neg", s_neg, 0);
      check("rst_b_valid", b_out_valid, 0);
      @(negedge clk);
      rst_n = 1'b1;
      tick;
      check("rst_s_ready", s_in_ready, 1);
      check("rst_b_ready", b_in_ready, 1);

      // Directed cases on the small instance
      small_run(8'b00_00_00_00, 8'h00, 1'b0, 1'b1, 0);
      small_run(8'b01_00_00_11, 8'b00_11_11_11, 1'b0, 1'b0, 0);
      small_run(8'b00_00_00_11, 8'hFF, 1'b1, 1'b1, 0);
      small_run(8'b01_10_10_10, 8'h6A, 1'b0, 1'b0, 5);

      // Reset during the second conversion beat
      s_w1       = 8'b01_10_10_10;
      s_in_valid = 1'b1;
      tick;
      s_in_valid = 1'b0;
      tick;
      rst_n = 1'b0;
      #1;
      check("mid_rst_valid", s_out_valid, 0);
      check("mid_rst_q", s_q, 0);
      check("mid_rst_neg", s_neg, 0);
      @(negedge clk);
      rst_n = 1'b1;
      tick;
      check("mid_rst_ready", s_in_ready, 1);
      small_run(8'b01_00_00_11, 8'b00_11_11_11, 1'b0, 1'b0, 0);

      // Random vectors on the default-size instance, next vector offered during DONE
      b_out_ready = 1'b1;
      prev_cyc    = 0;
      for (int n = 0; n < 150; n++) begin
         r = {$urandom, $urandom, $urandom};
         v = r[67:0];
         if (n % 4 == 0) v[67:66] = 2'b01;
         if (n == 1) v = '1;
         if (n == 2) v = '0;
         b_w1       = v;
         b_in_valid = 1'b1;
         k = 0;
         while (!b_in_ready && k < 20) begin
            tick;
            k++;
         end
         check("b_accept", b_in_ready, 1);
         acc_cyc = cyc;
         tick;
         b_in_valid = 1'b0;
         lat = 1;
         while (!b_out_valid && lat < 30) begin
            tick;
            lat++;
         end
         val = w1_value({4'b0, v}, 34);
         check("b_latency", lat, 10);
         check("b_q", b_q, val[67:0]);
         check("b_neg", b_neg, val < 0);
`ifdef W1_DETRANS_TOPCHK_EN
         check("b_err", b_err, v[67:66] != 2'b01);
`endif
         if (n > 0) check("b_period", acc_cyc - prev_cyc, 11);
         prev_cyc = acc_cyc;
      end
      tick;

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

   initial begin
      #500000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1);
   end

endmodule

// File: doc/w1_detrans.md
Name: w1_detrans

Overview:
- Inverse of the W1 operand transform. Takes a (p+1)-digit W1-coded radix-4 signed-digit vector, such as a multiplier result in W1 form, and converts it to a standard unsigned radix-4 (plain binary) vector plus a sign/borrow flag.
- Conversion is serial over digit chunks, LSB chunk first, with a registered borrow. This keeps the carry chain short at large p.
- Sits at the output side of the four-valued multiplier datapath. Uses valid/ready handshakes on both ends.

Parameters:
- p, 33: number of operand digits. The vector carries p+1 digits, 2p+2 bits.
- CHUNK, 4: digits converted per cycle. Must be 1..p+1.

Ports:
- clk  input  1  system clock, rising edge.
- rst_n  input  1  asynchronous active-low reset.
- in_valid  input  1  w1 vector valid.
- in_ready  output  1  block can accept a vector.
- w1  input  2p+2  W1-coded digit vector; digit i is w1[2i+1:2i].
- out_valid  output  1  result valid.
- out_ready  input  1  consumer accepts result.
- q  output  2p+2  converted value mod 4^(p+1); standard radix-4, digit i is q[2i+1:2i].
- neg  output  1  final borrow; 1 means the signed value is negative and q is its 4^(p+1) complement.
- err  output  1  marker error; present only with W1_DETRANS_TOPCHK_EN.

Behaviour:
- Digit coding:
  - 00 = 0
  - 01 = +1
  - 10 = +2
  - 11 = -1
- Value of the input is sum(d_i * 4^i), i = 0..p.
- Per digit, with borrow b in {0, -1} and s = d_i + b:
  - s in 0..2: out digit = s, b = 0.
  - s = -1: out digit = 3, b = -1.
  - s = -2: out digit = 2, b = -1.
  - s = 3 cannot occur.
- Within a chunk the borrow ripples combinationally. It is registered between chunks and starts at 0.
- NBEAT = ceil((p+1)/CHUNK). In the last chunk, digit positions above p are ignored.
- FSM, 3 states:
  - IDLE: in_ready = 1. On in_valid & in_ready, capture w1 into the shift register, clear borrow, set beat counter = 0, go to CONV.
  - CONV: in_ready = 0. Each cycle convert chunk[beat], write its digits into the q register at positions beat*CHUNK.., update borrow, increment beat. After beat NBEAT-1 completes, load neg = (borrow == -1) and go to DONE.
  - DONE: out_valid = 1. q and neg are stable and unchanged while out_valid & !out_ready. On out_ready go to IDLE.
- Latency: result is visible NBEAT+1 cycles after the accept edge. Throughput is one vector per NBEAT+2 cycles; no overlap.
- in_valid during CONV/DONE is ignored; in_ready is low, so there is no loss under a legal handshake.
- out_ready asserted outside DONE has no effect.
- Reset, asynchronous, at any time including mid-CONV: state = IDLE, in_ready = 1 after release, out_valid = 0, q = 0, neg = 0, err = 0, borrow = 0, beat = 0. A partial conversion is discarded.
- Outputs are registered. Nothing combinational runs from inputs to outputs except in_ready, which is decoded from state.

Optional Feature:
- Macro W1_DETRANS_TOPCHK_EN.
- Defined:
  - A well-formed W1 vector has top digit w1[2p+1:2p] = 01.
  - On accept, err is registered as (top digit != 01). It is valid alongside out_valid and held until the next accept or reset.
  - Conversion proceeds regardless of err.
- Undefined: the err port is absent and no check logic is built. All other behaviour is identical.

Test Plan:
- Test build p=3, CHUNK=2: NBEAT=2, w1 is 8 bits.
- Zero: w1=8'b00_00_00_00 -> after 3 cycles out_valid=1, q=8'h00, neg=0.
- Borrow ripple: w1=8'b01_00_00_11 (+64-1=63) -> q=8'b00_11_11_11, neg=0. With TOPCHK, err=0.
- Negative: w1=8'b00_00_00_11 (-1) -> q=8'hFF, neg=1. With TOPCHK, err=1.
- Pass-through and backpressure: w1=8'b01_10_10_10 (106) -> q=8'h6A, neg=0. Hold out_ready=0 for 5 cycles: q, neg and out_valid stay constant, in_ready stays 0, and a second in_valid is not accepted.
- Reset mid-op: accept a vector, assert rst_n=0 during CONV beat 1 -> out_valid=0, q=0, neg=0 immediately. After release, in_ready=1 and the next vector converts correctly.
- Default build p=33, CHUNK=4: random W1 vectors with back-to-back handshakes -> q/neg match the reference model sum(d_i*4^i) mod 4^34 and its sign; latency is exactly 10 cycles.
